// File: rtl/tx_sym_build_pkg.sv
// rtl/tx_sym_build_pkg.sv - constants shared by the TX symbol builder and the RX channel estimator
// Holds the Q2.14 unit levels, the 52-entry long-training sign table (bit u set = -1,
// u = 0..51 over used bins 1..26 then 38..63), pilot bins with base signs, the null-bin
// range, the FSM state codes and small bin-classification helpers.
package tx_sym_build_pkg;

    localparam logic [15:0] LP_P = 16'h3fff;
    localparam logic [15:0] LP_N = 16'hc001;

    // Bits [25:0] cover subcarriers +1..+26, bits [51:26] cover subcarriers -26..-1.
    localparam logic [51:0] LTS_NEG = {26'b00001010011000000101001100,
                                       26'b00001010110011111010100110};

    localparam logic [3:0][5:0] PILOT_BIN      = {6'd57, 6'd43, 6'd21, 6'd7};
    localparam logic [3:0]      PILOT_BASE_NEG = 4'b0010;

    localparam logic [5:0] NULL_LO = 6'd27;
    localparam logic [5:0] NULL_HI = 6'd37;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LTS  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_PAD  = 2'd3;

    function automatic logic is_null(input logic [5:0] bin);
        return (bin == 6'd0) || ((bin >= NULL_LO) && (bin <= NULL_HI));
    endfunction

    function automatic logic is_pilot(input logic [5:0] bin);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bin == PILOT_BIN[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic pilot_base_neg(input logic [5:0] bin);
        logic neg;
        neg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bin == PILOT_BIN[i]) neg = PILOT_BASE_NEG[i];
        end
        return neg;
    endfunction

    // Used-carrier index for the LTS table; only meaningful for non-null bins.
    function automatic logic [5:0] used_idx(input logic [5:0] bin);
        return (bin <= 6'd26) ? (bin - 6'd1) : (bin - 6'd12);
    endfunction

endpackage

// File: rtl/tx_sym_build_if.sv
// rtl/tx_sym_build_if.sv - Wishbone-style streaming bus of the symbol builder
// Upstream: DAT_I/WE_I/STB_I/CYC_I in, ACK_O out. Downstream: DAT_O/CYC_O/STB_O/WE_O out,
// ACK_I in. The slave modport is the builder's view, master is the environment's view.
interface tx_sym_build_if;
    import tx_sym_build_pkg::*;

    logic [31:0] DAT_I;
    logic        WE_I;
    logic        STB_I;
    logic        CYC_I;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic        ACK_I;

    modport slave (
        input  DAT_I, WE_I, STB_I, CYC_I, ACK_I,
        output ACK_O, DAT_O, CYC_O, STB_O, WE_O
    );

    modport master (
        output DAT_I, WE_I, STB_I, CYC_I, ACK_I,
        input  ACK_O, DAT_O, CYC_O, STB_O, WE_O
    );
endinterface

// File: rtl/tx_sym_build_pilot_pn_gen.sv
// rtl/tx_sym_build_pilot_pn_gen.sv - pilot polarity LFSR, x^7+x^4+1
// Ports: clk, rst_n (async, active-low), seed (load 7'h7f), step (advance one symbol),
// pol_neg (1 = pilots inverted for the current data symbol).
module pilot_pn_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic seed,
    input  logic step,
    output logic pol_neg
);

    logic [6:0] s_q;
    logic [6:0] s_d;

    always_comb begin
        s_d = s_q;
        if (seed) begin
            s_d = 7'h7f;
        end else if (step) begin
            s_d = {s_q[5:0], s_q[6] ^ s_q[3]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 7'h7f;
        end else begin
            s_q <= s_d;
        end
    end

    assign pol_neg = s_q[6] ^ s_q[3];

endmodule

// File: rtl/tx_sym_build.sv
// rtl/tx_sym_build.sv - 802.11a TX frequency-domain symbol builder (LTS + data/pilot packing)
// Ports: CLK_I clock, RST_I async active-low reset, bus (slave modport): mapped carriers in
// on DAT_I/WE_I/STB_I/CYC_I with ACK_O, 64-bin FFT-order samples out on DAT_O/STB_O/CYC_O/WE_O
// with ACK_I. Each frame emits LTS_REP long-training symbols, then one symbol per 48 inputs.
module tx_sym_build
    import tx_sym_build_pkg::*;
#(
    parameter int unsigned LTS_REP = 2
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    tx_sym_build_if.slave bus
);

    localparam logic [1:0] REP_LAST = 2'(LTS_REP - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  bin_q, bin_d;
    logic [1:0]  rep_q, rep_d;
    logic        cyc_in_q, cyc_in_d;
    logic [31:0] dat_o_q, dat_o_d;
    logic        stb_o_q, stb_o_d;
    logic        cyc_o_q, cyc_o_d;

    logic        istart;
    logic [1:0]  cur_state;
    logic        out_halt;
    logic        in_valid;
    logic        data_bin;
    logic        consume_bin;
    logic        data_stop;
    logic        advance;
    logic        sym_end;
    logic        pn_seed;
    logic        pn_step;
    logic        pol_neg;
    logic [31:0] sample;

    pilot_pn_gen u_pn (
        .clk     (CLK_I),
        .rst_n   (RST_I),
        .seed    (pn_seed),
        .step    (pn_step),
        .pol_neg (pol_neg)
    );

    always_comb begin
        istart   = bus.CYC_I & ~cyc_in_q;
        // istart is acted on in the same cycle so bin 0 of the first LTS is
        // registered on the very next edge.
        cur_state = ((state_q == ST_IDLE) && istart) ? ST_LTS : state_q;
        out_halt  = stb_o_q & ~bus.ACK_I;
        in_valid  = bus.WE_I & bus.STB_I & bus.CYC_I;
        data_bin  = ~is_null(bin_q) & ~is_pilot(bin_q);
        consume_bin = (cur_state == ST_DATA) & data_bin;
        // CYC_I low before a data symbol has started ends the frame without
        // padding out a whole empty symbol.
        data_stop = (cur_state == ST_DATA) & ~bus.CYC_I & (bin_q == 6'd0);
        advance   = ~out_halt & (cur_state != ST_IDLE) & ~data_stop
                  & (~consume_bin | in_valid);
        sym_end   = advance & (bin_q == 6'd63);
        pn_seed   = (state_q == ST_IDLE) & istart;
        pn_step   = (cur_state == ST_DATA) & sym_end;
    end

    always_comb begin
        sample = 32'd0;
        if (!is_null(bin_q)) begin
            case (cur_state)
                ST_LTS: begin
                    sample = {16'd0, LTS_NEG[used_idx(bin_q)] ? LP_N : LP_P};
                end
                ST_DATA, ST_PAD: begin
                    if (is_pilot(bin_q)) begin
                        sample = {16'd0, (pilot_base_neg(bin_q) ^ pol_neg) ? LP_N : LP_P};
                    end else if (cur_state == ST_DATA) begin
                        sample = bus.DAT_I;
                    end
                end
                default: sample = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        rep_d    = rep_q;
        dat_o_d  = dat_o_q;
        stb_o_d  = stb_o_q;
        cyc_o_d  = cyc_o_q;
        cyc_in_d = bus.CYC_I;

        if (!out_halt) stb_o_d = 1'b0;
        if (advance) begin
            dat_o_d = sample;
            stb_o_d = 1'b1;
            bin_d   = bin_q + 6'd1;
        end

        case (cur_state)
            ST_IDLE: begin
                // The final sample of a frame may still be waiting for ACK_I.
                if (!out_halt) cyc_o_d = 1'b0;
            end
            ST_LTS: begin
                state_d = ST_LTS;
                cyc_o_d = 1'b1;
                if (sym_end) begin
                    if (rep_q == REP_LAST) begin
                        state_d = ST_DATA;
                        rep_d   = 2'd0;
                    end else begin
                        rep_d = rep_q + 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (data_stop) begin
                    state_d = ST_IDLE;
                    if (!out_halt) cyc_o_d = 1'b0;
                end else if (sym_end) begin
                    state_d = bus.CYC_I ? ST_DATA : ST_IDLE;
                end else if (!bus.CYC_I) begin
                    state_d = ST_PAD;
                end
            end
            default: begin
                if (sym_end) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q  <= ST_IDLE;
            bin_q    <= 6'd0;
            rep_q    <= 2'd0;
            cyc_in_q <= 1'b0;
            dat_o_q  <= 32'd0;
            stb_o_q  <= 1'b0;
            cyc_o_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            rep_q    <= rep_d;
            cyc_in_q <= cyc_in_d;
            dat_o_q  <= dat_o_d;
            stb_o_q  <= stb_o_d;
            cyc_o_q  <= cyc_o_d;
        end
    end

    assign bus.ACK_O = consume_bin & in_valid & ~out_halt;
    assign bus.DAT_O = dat_o_q;
    assign bus.STB_O = stb_o_q;
    assign bus.CYC_O = cyc_o_q;
    assign bus.WE_O  = cyc_o_q;

endmodule

// File: tb/tb_tx_sym_build.sv
// tb/tb_tx_sym_build.sv - directed self-checking bench for tx_sym_build
module tb_tx_sym_build;

    logic clk;
    logic rst_n;
    tx_sym_build_if b ();

    tx_sym_build #(.LTS_REP(2)) dut (
        .CLK_I (clk),
        .RST_I (rst_n),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 802.11a long training sequence, subcarriers -26..+26.
    int LTS_STD [53] = '{1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1, 1, 1, -1, -1, 1, 1, -1,
                         1, -1, 1, 1, 1, 1, 0, 1, -1, -1, 1, 1, -1, 1, -1, 1, -1, -1, -1, -1,
                         -1, 1, 1, -1, -1, 1, -1, 1, -1, 1, 1, 1, 1};
    // Pilot polarity for data symbols 0..4.
    int PPOL [5] = '{1, 1, 1, 1, -1};

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int halt_bad, ack_halt_bad, weo_bad;
    int first_stb_cyc, last_ack_cyc, fall_cyc, fall_cnt;
    bit timed_out, rst_hit;
    logic [31:0] rst_dat;
    logic rst_stb, rst_cyc, rst_ack;

    function automatic logic [31:0] lts_exp(input int bin);
        int k;
        k = (bin < 32) ? bin : bin - 64;
        if (bin == 0 || (bin >= 27 && bin <= 37)) return 32'd0;
        return (LTS_STD[k + 26] < 0) ? 32'h0000_c001 : 32'h0000_3fff;
    endfunction

    function automatic void build_exp(input int n_sym, input int n_data, input logic [31:0] base);
        int d;
        int k;
        int sg;
        d = 0;
        exp_q.delete();
        for (int r = 0; r < 2; r++)
            for (int bn = 0; bn < 64; bn++) exp_q.push_back(lts_exp(bn));
        for (int s = 0; s < n_sym; s++) begin
            for (int bn = 0; bn < 64; bn++) begin
                k = (bn < 32) ? bn : bn - 64;
                if (bn == 0 || (bn >= 27 && bn <= 37)) begin
                    exp_q.push_back(32'd0);
                end else if (k == 7 || k == -7 || k == 21 || k == -21) begin
                    sg = (k == 21) ? -1 : 1;
                    sg = sg * PPOL[s];
                    exp_q.push_back(sg < 0 ? 32'h0000_c001 : 32'h0000_3fff);
                end else begin
                    exp_q.push_back(d < n_data ? base + 32'(d) : 32'd0);
                    d++;
                end
            end
        end
    endfunction

    function automatic int first_bad();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got.size() || got[i] !== exp_q[i]) return i;
        return (got.size() > exp_q.size()) ? exp_q.size() : -1;
    endfunction

    function automatic logic [31:0] got_at(input int i);
        if (i < 0 || i >= got.size()) return 32'hxxxx_xxxx;
        return got[i];
    endfunction

    function automatic logic [31:0] exp_at(input int i);
        if (i < 0 || i >= exp_q.size()) return 32'hxxxx_xxxx;
        return exp_q[i];
    endfunction

    // Drives one frame and records every accepted output sample.
    task automatic run_frame(input int n_in, input int drop_at, input bit rnd_ack,
                             input int rst_at, input logic [31:0] base);
        int sent;
        int cyc;
        bit dropped;
        bit acc;
        bit prev_halt;
        logic [31:0] prev_dat;
        sent = 0; cyc = 0; dropped = 0; acc = 0; prev_halt = 0; prev_dat = '0;
        got.delete();
        halt_bad = 0; ack_halt_bad = 0; weo_bad = 0; timed_out = 0; rst_hit = 0;
        first_stb_cyc = -1; last_ack_cyc = -1; fall_cyc = -1; fall_cnt = -1;
        @(posedge clk); #1;
        b.CYC_I = 1'b1; b.WE_I = 1'b1; b.STB_I = (n_in > 0); b.DAT_I = base;
        b.ACK_I = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
        forever begin
            @(negedge clk);
            if (prev_halt && (b.DAT_O !== prev_dat || b.STB_O !== 1'b1)) halt_bad++;
            if (b.STB_O && !b.ACK_I && b.ACK_O) ack_halt_bad++;
            if (b.WE_O !== b.CYC_O) weo_bad++;
            if (b.STB_O === 1'b1 && first_stb_cyc < 0) first_stb_cyc = cyc;
            if (b.STB_O === 1'b1 && b.ACK_I) begin
                got.push_back(b.DAT_O);
                last_ack_cyc = cyc;
            end
            if (first_stb_cyc >= 0 && b.CYC_O === 1'b0 && fall_cyc < 0) begin
                fall_cyc = cyc;
                fall_cnt = got.size();
            end
            prev_halt = b.STB_O & ~b.ACK_I;
            prev_dat = b.DAT_O;
            acc = b.ACK_O;
            if (rst_at > 0 && got.size() == rst_at) begin
                rst_n = 1'b0;
                #1;
                rst_dat = b.DAT_O; rst_stb = b.STB_O; rst_cyc = b.CYC_O; rst_ack = b.ACK_O;
                rst_hit = 1;
                break;
            end
            if (dropped && b.CYC_O === 1'b0 && b.STB_O === 1'b0) break;
            if (cyc >= 3000) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) sent++;
            if (!dropped && (sent == n_in || sent == drop_at)) begin
                dropped = 1;
                b.CYC_I = 1'b0;
                b.STB_I = 1'b0;
            end
            b.DAT_I = base + 32'(sent);
            if (rnd_ack) b.ACK_I = 1'($urandom_range(0, 1));
        end
        b.CYC_I = 1'b0; b.STB_I = 1'b0; b.ACK_I = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b.CYC_I = 1'b1; b.STB_I = 1'b1; b.WE_I = 1'b1; b.DAT_I = 32'hdead_beef; b.ACK_I = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (b.DAT_O !== 32'd0) begin tests_failed++; $display("FAIL reset_dat: got %h exp 00000000", b.DAT_O); end
        tests_run++;
        if (b.STB_O !== 1'b0) begin tests_failed++; $display("FAIL reset_stb: got %b exp 0", b.STB_O); end
        tests_run++;
        if (b.CYC_O !== 1'b0) begin tests_failed++; $display("FAIL reset_cyc: got %b exp 0", b.CYC_O); end
        tests_run++;
        if (b.ACK_O !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b exp 0", b.ACK_O); end
        b.CYC_I = 1'b0; b.STB_I = 1'b0; b.ACK_I = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame();
        int bad;
        logic [31:0] base;
        base = 32'h0001_0000;
        run_frame(48, -1, 1'b0, 0, base);
        build_exp(1, 48, base);
        tests_run++;
        if (timed_out) begin tests_failed++; $display("FAIL frame_timeout: got %0d samples before cycle limit", got.size()); end
        tests_run++;
        if (got.size() != 192) begin tests_failed++; $display("FAIL frame_count: got %0d exp 192", got.size()); end
        bad = first_bad();
        tests_run++;
        if (bad >= 0) begin tests_failed++; $display("FAIL frame_stream: idx %0d got %h exp %h", bad, got_at(bad), exp_at(bad)); end
        bad = 0;
        if (got.size() < 192) bad = 1;
        else begin
            if (got[0] !== 32'd0 || got[64] !== 32'd0) bad = 1;
            for (int i = 27; i <= 37; i++) if (got[128 + i] !== 32'd0 || got[i] !== 32'd0) bad = 1;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL frame_nulls: bin0 %h bin64 %h bin27 %h", got_at(0), got_at(64), got_at(27)); end
        tests_run++;
        if (got_at(1) !== 32'h0000_3fff) begin tests_failed++; $display("FAIL lts_bin1: got %h exp 00003fff", got_at(1)); end
        tests_run++;
        if (got_at(129) !== 32'h0001_0000) begin tests_failed++; $display("FAIL data_bin1: got %h exp 00010000", got_at(129)); end
        tests_run++;
        if (got_at(135) !== 32'h0000_3fff) begin tests_failed++; $display("FAIL pilot_bin7: got %h exp 00003fff", got_at(135)); end
        tests_run++;
        if (got_at(149) !== 32'h0000_c001) begin tests_failed++; $display("FAIL pilot_bin21: got %h exp 0000c001", got_at(149)); end
        tests_run++;
        if (first_stb_cyc != 1) begin tests_failed++; $display("FAIL first_latency: got %0d exp 1", first_stb_cyc); end
        tests_run++;
        if (fall_cnt != 192) begin tests_failed++; $display("FAIL cyc_fall_count: got %0d exp 192", fall_cnt); end
        tests_run++;
        if (fall_cyc != last_ack_cyc + 1) begin tests_failed++; $display("FAIL cyc_fall_time: got %0d exp %0d", fall_cyc, last_ack_cyc + 1); end
        tests_run++;
        if (weo_bad != 0) begin tests_failed++; $display("FAIL we_o: got %0d mismatching cycles exp 0", weo_bad); end
    endtask

    task automatic test_backpressure();
        int bad;
        logic [31:0] base;
        base = 32'h00a0_0100;
        run_frame(144, -1, 1'b1, 0, base);
        build_exp(3, 144, base);
        tests_run++;
        if (timed_out) begin tests_failed++; $display("FAIL bp_timeout: got %0d samples before cycle limit", got.size()); end
        tests_run++;
        if (halt_bad != 0) begin tests_failed++; $display("FAIL bp_hold: got %0d unstable halt cycles exp 0", halt_bad); end
        tests_run++;
        if (ack_halt_bad != 0) begin tests_failed++; $display("FAIL bp_ack_o: got %0d ACK_O during halt exp 0", ack_halt_bad); end
        tests_run++;
        if (got.size() != 320) begin tests_failed++; $display("FAIL bp_count: got %0d exp 320", got.size()); end
        bad = first_bad();
        tests_run++;
        if (bad >= 0) begin tests_failed++; $display("FAIL bp_stream: idx %0d got %h exp %h", bad, got_at(bad), exp_at(bad)); end
    endtask

    task automatic test_pilot_polarity();
        int bad;
        logic [31:0] base;
        logic [31:0] want;
        base = 32'h0500_0000;
        run_frame(240, -1, 1'b0, 0, base);
        build_exp(5, 240, base);
        for (int s = 0; s < 5; s++) begin
            want = (PPOL[s] < 0) ? 32'h0000_c001 : 32'h0000_3fff;
            tests_run++;
            if (got_at(128 + 64 * s + 7) !== want) begin
                tests_failed++;
                $display("FAIL pol_sym%0d_bin7: got %h exp %h", s, got_at(128 + 64 * s + 7), want);
            end
        end
        bad = first_bad();
        tests_run++;
        if (bad >= 0) begin tests_failed++; $display("FAIL pol_stream: idx %0d got %h exp %h", bad, got_at(bad), exp_at(bad)); end
    endtask

    task automatic test_early_drop();
        int bad;
        logic [31:0] base;
        base = 32'h0700_0000;
        run_frame(200, 68, 1'b0, 0, base);
        build_exp(2, 68, base);
        tests_run++;
        if (got.size() != 256 || timed_out) begin tests_failed++; $display("FAIL drop_count: got %0d exp 256", got.size()); end
        bad = first_bad();
        tests_run++;
        if (bad >= 0) begin tests_failed++; $display("FAIL drop_stream: idx %0d got %h exp %h", bad, got_at(bad), exp_at(bad)); end
        tests_run++;
        if (got_at(199) !== 32'h0000_3fff || got_at(213) !== 32'h0000_c001 ||
            got_at(235) !== 32'h0000_3fff || got_at(249) !== 32'h0000_3fff) begin
            tests_failed++;
            $display("FAIL drop_pilots: got %h %h %h %h exp 3fff c001 3fff 3fff", got_at(199), got_at(213), got_at(235), got_at(249));
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (b.CYC_O !== 1'b0 || fall_cyc != last_ack_cyc + 1) begin
            tests_failed++;
            $display("FAIL drop_cyc_o: got %b fall %0d exp 0 fall %0d", b.CYC_O, fall_cyc, last_ack_cyc + 1);
        end
    endtask

    task automatic test_reset_midframe();
        int bad;
        logic [31:0] base;
        base = 32'h0900_0000;
        run_frame(48, -1, 1'b0, 100, 32'h0800_0000);
        tests_run++;
        if (!rst_hit) begin tests_failed++; $display("FAIL rst_reach: got %0d samples exp 100", got.size()); end
        tests_run++;
        if (rst_dat !== 32'd0 || rst_stb !== 1'b0 || rst_cyc !== 1'b0 || rst_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_clear: got dat %h stb %b cyc %b ack %b exp all 0", rst_dat, rst_stb, rst_cyc, rst_ack);
        end
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(48, -1, 1'b0, 0, base);
        build_exp(1, 48, base);
        tests_run++;
        if (got.size() != 192 || timed_out) begin tests_failed++; $display("FAIL rst_restart_count: got %0d exp 192", got.size()); end
        bad = first_bad();
        tests_run++;
        if (bad >= 0) begin tests_failed++; $display("FAIL rst_restart_stream: idx %0d got %h exp %h", bad, got_at(bad), exp_at(bad)); end
    endtask

    initial begin
        rst_n = 1'b0;
        b.DAT_I = '0; b.WE_I = 1'b0; b.STB_I = 1'b0; b.CYC_I = 1'b0; b.ACK_I = 1'b1;
        test_reset();
        test_frame();
        test_backpressure();
        test_pilot_polarity();
        test_early_drop();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/tx_sym_build.md
# tx_sym_build

Transmit-side frequency-domain symbol builder for the 802.11a OFDM TX chain, sitting between the constellation mapper and the IFFT. At frame start it emits LTS_REP long-training symbols built from the 52-entry long-preamble sign table shared with the receiver's channel estimator. It then packs every 48 mapped data carriers into a 64-bin symbol with nulls and polarity-scrambled pilots inserted. Input and output are Wishbone-style streaming handshakes.

## Interface
- LTS_REP, 2, long-training symbols emitted per frame (1..3)
- LP_P, 16'h3fff, +1 in Q2.14
- LP_N, 16'hc001, -1 in Q2.14
- CLK_I  in  1  single clock, rising edge
- RST_I  in  1  reset, asynchronous, active-low
- DAT_I  in  32  mapped carrier, [31:16] Im, [15:0] Re, Q2.14
- WE_I, STB_I, CYC_I  in  1 each  input strobe; CYC_I frames the packet
- ACK_O  out  1  input accepted this cycle
- DAT_O  out  32  bin sample, [31:16] Im, [15:0] Re
- CYC_O, STB_O  out  1 each  output frame and valid
- WE_O  out  1  equals CYC_O
- ACK_I  in  1  downstream accepts DAT_O

## Operation
- Bin order per symbol: bin 0..63, FFT order.
  - Bin 0 and bins 27..37 are null (32'd0).
  - Used bins are 1..26 and 38..63; used index u = 0..51 in that order addresses the LTS table.
- States:
  - IDLE -> LTS on istart = CYC_I & ~CYC_I_d.
  - LTS -> DATA after LTS_REP×64 samples.
  - DATA -> DATA at symbol end if CYC_I is high.
  - DATA -> IDLE at symbol end if CYC_I is low.
  - DATA -> PAD when CYC_I falls mid-symbol.
  - PAD -> IDLE at symbol end.
- LTS sample: null bins 0; used bins Re = table[u] ? LP_N : LP_P, Im = 0.
- Pilot bins in DATA: 7, 21, 43, 57.
  - Base sign +,−,+,+ respectively, multiplied by polarity p.
  - Im = 0; Re = LP_P or LP_N.
- Data bins: the remaining 48 used bins in ascending order (1–6, 8–20, 22–26, 38–42, 44–56, 58–63).
  - Filled with consecutive accepted DAT_I words, unmodified.
  - In PAD, data bins are 32'd0 and nothing is consumed.
- Polarity p comes from a 7-bit LFSR x^7+x^4+1.
  - Seeded 7'h7f at istart; output bit = s[6]^s[3]; 0 → +1, 1 → −1.
  - Steps once at each DATA symbol end (first data symbol uses p0 = +1).
- Output register:
  - out_halt = STB_O & ~ACK_I.
  - advance = ~out_halt & (bin is not a DATA data-bin | (WE_I & STB_I & CYC_I)).
  - ACK_O = DATA state & data-bin & WE_I & STB_I & CYC_I & ~out_halt.
- CYC_O:
  - Set on IDLE → LTS.
  - Cleared the cycle after the final bin-63 sample is acknowledged.

## Timing
- Reset values: DAT_O = 0, STB_O = 0, CYC_O = 0, all counters and state = 0/IDLE, LFSR = 7'h7f. ACK_O = 0 while in reset.
- Latency: an accepted input appears on DAT_O with STB_O the next cycle. The first LTS sample appears 1 cycle after istart is seen.
- Throughput is 1 bin per cycle with ACK_I held high.
- STB_O stalls only when DATA is waiting on input.
- DAT_O and STB_O hold stable while out_halt is set.
- istart while not IDLE is ignored.
- Async reset mid-frame: outputs clear immediately. Next istart restarts from the LTS.
- Bin counter wraps 63 → 0. The LTS repetition counter and the symbol end share that wrap.

## Structure
- Shared TX/RX package holds:
  - LP_P and LP_N.
  - The 52-bit LTS sign constant, the same one used by the receiver estimator.
  - Pilot bin indices and base signs.
  - Null-bin ranges.
  - The state enum.
- One sub-module, pilot_pn_gen: LFSR with seed/step inputs and a polarity output.

## Test plan
- Reset asserted with arbitrary inputs -> DAT_O = 0, STB_O = 0, CYC_O = 0, ACK_O = 0.
- One frame of 48 inputs 32'h0001_0000+k, ACK_I = 1, LTS_REP = 2 -> 192 samples total.
  - Bins 0, 27–37 and 64 are 0 (bin 64 is bin 0 of the second LTS symbol).
  - Data bin 1 = 32'h0001_0000, bin 7 = 32'h0000_3fff, bin 21 = 32'h0000_c001.
  - CYC_O falls after sample 191.
- Random ACK_I backpressure, 3 data symbols -> DAT_O stable during every halt, ACK_O = 0 during halt, all 144 inputs appear once and in order.
- 5 data symbols -> bin 7 Re = 3fff, 3fff, 3fff, 3fff, c001 for symbols 0..4.
- CYC_I drops after 20 inputs of a symbol -> the remaining 28 data bins = 0, pilots intact, 64 bins completed, CYC_O low afterwards.
- RST_I low at sample 100 -> immediate output clear; next CYC_I rise restarts at LTS bin 0 with LFSR reseeded.
